// File: rtl/score_keeper.sv
// score_keeper: 4-digit BCD game score and lives tracker feeding the seven-segment counter.
// Latency: start->PLAY 3 cycles, win->score 5 cycles, collision->lives 1 cycle after detection.
// No backpressure: level inputs are edge-detected; wins and collisions are dropped per the rules below.
// Optional feature macro SCORE_TIME_BONUS_EN: round timer, 1 Hz divider and time bonus on each win.
module score_keeper #(
  parameter int          CLK_HZ        = 100_000_000,
  parameter logic [15:0] ROUND_PTS     = 16'h0100,
  parameter logic [7:0]  ROUND_SECS    = 8'h60,
  parameter logic [1:0]  LIVES_INIT    = 2'd3,
  parameter int          INVULN_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        wonFirstRound,
  input  logic        wonSecondRound,
  input  logic        wonThirdRound,
  input  logic        wonFourthRound,
  input  logic        collidedWithEnemy,
  output logic [15:0] displayNumber,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        busy
);

  localparam int INV_W = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES + 1) : 1;
  localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, ADD = 2'd2, OVER = 2'd3} stateType;
  stateType state, nextState;

  logic             startSync1, startSync2, startPrev, startPulse;
  logic [3:0]       wonNow, wonPrev;
  logic             collidedPrev, collisionHit;
  logic             winEvent, winPend, dead;
  logic [INV_W-1:0] invuln;
  logic [1:0]       digitIdx, carry, carryNext;
  logic [15:0]      workSum;
  logic [3:0]       scoreDigit, ptsDigit, bonusDigit, sumDigit;
  logic [4:0]       digitSum;
  logic             inGame, startGo, consumeWin, commitAdd, enterOver, hitTaken;

  assign wonNow     = {wonFourthRound, wonThirdRound, wonSecondRound, wonFirstRound};
  // Several rounds rising together still count as a single win
  assign winEvent   = |(wonNow & ~wonPrev);
  assign inGame     = (state == PLAY) || (state == ADD);
  assign startGo    = startPulse && ((state == IDLE) || (state == OVER));
  assign consumeWin = (state == PLAY) && !dead && winPend;
  assign commitAdd  = (state == ADD) && (digitIdx == 2'd3);
  assign enterOver  = (nextState == OVER) && (state != OVER);
  assign hitTaken   = collisionHit && inGame && (invuln == '0) && !dead;

  // Start switch: two-flop synchroniser, then a registered rising-edge pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      startSync1 <= 1'b0;
      startSync2 <= 1'b0;
      startPrev  <= 1'b0;
      startPulse <= 1'b0;
    end else begin
      startSync1 <= start;
      startSync2 <= startSync1;
      startPrev  <= startSync2;
      startPulse <= startSync2 & ~startPrev;
    end
  end

  // Previous-sample registers; a collision edge is registered and acted on one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wonPrev      <= 4'b0000;
      collidedPrev <= 1'b0;
      collisionHit <= 1'b0;
    end else begin
      wonPrev      <= wonNow;
      collidedPrev <= collidedWithEnemy;
      collisionHit <= collidedWithEnemy & ~collidedPrev;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: death beats a pending win in PLAY, but an add in flight always finishes
  always_comb begin
    nextState = state;
    case (state)
      IDLE, OVER: if (startPulse) nextState = PLAY;
      PLAY: begin
        if (dead)         nextState = OVER;
        else if (winPend) nextState = ADD;
      end
      ADD: if (digitIdx == 2'd3) nextState = dead ? OVER : PLAY;
      default: nextState = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    busy      = (state == ADD);
    game_over = (state == OVER);
  end

  // One-deep pending win; set only while a game is running, flushed when the game ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     winPend <= 1'b0;
    else if (startGo || enterOver)  winPend <= 1'b0;
    else                            winPend <= (winPend & ~consumeWin) | (winEvent & inGame);
  end

  // Lives and the post-hit invulnerability window
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lives  <= LIVES_INIT;
      dead   <= 1'b0;
      invuln <= '0;
    end else if (startGo) begin
      lives  <= LIVES_INIT;
      dead   <= 1'b0;
      invuln <= '0;
    end else if (hitTaken) begin
      lives  <= lives - 2'd1;
      invuln <= INV_LOAD;
      if (lives == 2'd1) dead <= 1'b1;
    end else if (invuln != '0) begin
      invuln <= invuln - INV_W'(1);
    end
  end

`ifdef SCORE_TIME_BONUS_EN
  localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

  logic [DIV_W-1:0] divCount;
  logic [7:0]       timer, bonus;
  logic             secTick;

  assign secTick = inGame && (divCount == DIV_LAST);

  // 1 Hz divider, frozen outside a running game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      divCount <= '0;
    else if (inGame) divCount <= secTick ? '0 : divCount + DIV_W'(1);
  end

  // Round timer: BCD countdown saturating at 00, reloaded at game start and after each add
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     timer <= ROUND_SECS;
    else if (startGo || commitAdd)  timer <= ROUND_SECS;
    else if (secTick && (timer != 8'h00)) begin
      if (timer[3:0] == 4'd0) timer <= {timer[7:4] - 4'd1, 4'd9};
      else                    timer <= {timer[7:4], timer[3:0] - 4'd1};
    end
  end

  // Bonus snapshot of the timer taken as the add starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          bonus <= 8'h00;
    else if (consumeWin) bonus <= timer;
  end
`else
  logic unusedCfg;
  assign unusedCfg = ^{ROUND_SECS, CLK_HZ};
`endif

  // One BCD digit of score + round points + bonus + carry; carry can reach 2
  always_comb begin
    scoreDigit = displayNumber[{digitIdx, 2'b00} +: 4];
    ptsDigit   = ROUND_PTS[{digitIdx, 2'b00} +: 4];
`ifdef SCORE_TIME_BONUS_EN
    bonusDigit = digitIdx[1] ? 4'd0 : bonus[{digitIdx[0], 2'b00} +: 4];
`else
    bonusDigit = 4'd0;
`endif
    digitSum   = 5'(scoreDigit) + 5'(ptsDigit) + 5'(bonusDigit) + 5'(carry);
    if (digitSum >= 5'd20) begin
      sumDigit  = 4'(digitSum - 5'd20);
      carryNext = 2'd2;
    end else if (digitSum >= 5'd10) begin
      sumDigit  = 4'(digitSum - 5'd10);
      carryNext = 2'd1;
    end else begin
      sumDigit  = digitSum[3:0];
      carryNext = 2'd0;
    end
  end

  // Digit-serial add into a working register; the score only changes as a whole on the last digit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      displayNumber <= 16'h0000;
      workSum       <= 16'h0000;
      digitIdx      <= 2'd0;
      carry         <= 2'd0;
    end else if (startGo) begin
      displayNumber <= 16'h0000;
      digitIdx      <= 2'd0;
      carry         <= 2'd0;
    end else if (consumeWin) begin
      digitIdx      <= 2'd0;
      carry         <= 2'd0;
    end else if (state == ADD) begin
      workSum[{digitIdx, 2'b00} +: 4] <= sumDigit;
      carry    <= carryNext;
      digitIdx <= digitIdx + 2'd1;
      // Overflow past 9999 pins the score instead of wrapping
      if (commitAdd) displayNumber <= (carryNext != 2'd0) ? 16'h9999 : {sumDigit, workSum[11:0]};
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: random and directed stimulus against a cycle-level integer model.
module tb_score_keeper;
  localparam int          CLK_HZ     = 10;
  localparam logic [15:0] ROUND_PTS  = 16'h0100;
  localparam logic [7:0]  ROUND_SECS = 8'h60;
  localparam logic [1:0]  LIVES_INIT = 2'd3;
  localparam int          INVULN     = 20;
  localparam int          PTS        = 100;
  localparam int          SECS       = 60;
  localparam int M_IDLE = 0, M_PLAY = 1, M_ADD = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        reset, start, col;
  logic [3:0]  won;
  logic [15:0] displayNumber;
  logic [1:0]  lives;
  logic        game_over, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chkOn = 1'b0;

  // Model state, plain integers
  int mScore, mLives, mInv, mMode, mAddLeft;
  bit mDead, mPend, mColCand, mColPrev;
  logic [3:0] mWonPrev;
  logic [4:0] mHist;
`ifdef SCORE_TIME_BONUS_EN
  int mTimer, mDiv, mBonus;
`endif

  score_keeper #(
    .CLK_HZ(CLK_HZ), .ROUND_PTS(ROUND_PTS), .ROUND_SECS(ROUND_SECS),
    .LIVES_INIT(LIVES_INIT), .INVULN_CYCLES(INVULN)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .wonFirstRound(won[0]), .wonSecondRound(won[1]),
    .wonThirdRound(won[2]), .wonFourthRound(won[3]),
    .collidedWithEnemy(col),
    .displayNumber(displayNumber), .lives(lives),
    .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] toBcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic mReset();
    mScore = 0; mLives = LIVES_INIT; mInv = 0; mMode = M_IDLE; mAddLeft = 0;
    mDead = 0; mPend = 0; mColCand = 0; mColPrev = 0; mWonPrev = 4'b0; mHist = 5'b0;
`ifdef SCORE_TIME_BONUS_EN
    mTimer = SECS; mDiv = 0; mBonus = 0;
`endif
  endtask

  // One clock edge of the game rules, using the inputs sampled at this edge
  task automatic mStep();
    bit winE, colE, go, inGame, oDead, oPend, commit;
`ifdef SCORE_TIME_BONUS_EN
    bit secTick;
    int oTimer;
    oTimer = mTimer;
    secTick = 0;
`endif
    winE = |(won & ~mWonPrev);
    mWonPrev = won;
    colE = col && !mColPrev;
    mColPrev = col;
    mHist = {mHist[3:0], start};
    go = mHist[3] && !mHist[4];
    inGame = (mMode == M_PLAY) || (mMode == M_ADD);
    oDead = mDead;
    oPend = mPend;
    commit = 0;
    if (go && !inGame) begin
      mScore = 0; mLives = LIVES_INIT; mInv = 0; mDead = 0; mPend = 0; mMode = M_PLAY;
`ifdef SCORE_TIME_BONUS_EN
      mTimer = SECS;
`endif
    end else begin
      if (mColCand && inGame && mInv == 0 && !oDead) begin
        mLives = mLives - 1;
        mInv = INVULN;
        if (mLives == 0) mDead = 1;
      end else if (mInv > 0) begin
        mInv = mInv - 1;
      end
      case (mMode)
        M_PLAY: begin
          if (oDead) begin
            mMode = M_OVER; mPend = 0;
          end else if (oPend) begin
            mMode = M_ADD; mAddLeft = 4; mPend = winE;
`ifdef SCORE_TIME_BONUS_EN
            mBonus = oTimer;
`endif
          end else begin
            mPend = mPend || winE;
          end
        end
        M_ADD: begin
          mPend = mPend || winE;
          mAddLeft = mAddLeft - 1;
          if (mAddLeft == 0) begin
            commit = 1;
            mScore = mScore + PTS;
`ifdef SCORE_TIME_BONUS_EN
            mScore = mScore + mBonus;
`endif
            if (mScore > 9999) mScore = 9999;
            if (oDead) begin mMode = M_OVER; mPend = 0; end
            else mMode = M_PLAY;
          end
        end
        default: ;
      endcase
`ifdef SCORE_TIME_BONUS_EN
      if (inGame) begin
        secTick = (mDiv == CLK_HZ - 1);
        mDiv = secTick ? 0 : mDiv + 1;
      end
      if (commit) mTimer = SECS;
      else if (secTick && mTimer > 0) mTimer = mTimer - 1;
`else
      if (commit) mPend = mPend;
`endif
    end
    mColCand = colE;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) mStep();
    else mReset();
    cyc++;
    @(negedge clk);
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  // Every cycle: all outputs against the model
  always @(negedge clk) begin
    if (chkOn) begin
      check("displayNumber", displayNumber, toBcd(mScore));
      check("lives", lives, mLives);
      check("game_over", game_over, int'(mMode == M_OVER));
      check("busy", busy, int'(mMode == M_ADD));
    end
  end

  initial begin
    int e;
    int busyCnt;
    logic [15:0] expFirst;
`ifdef SCORE_TIME_BONUS_EN
    expFirst = 16'h0157;
`else
    expFirst = 16'h0100;
`endif
    reset = 1'b0; start = 1'b0; won = 4'b0; col = 1'b0;
    mReset();
    chkOn = 1'b1;
    tick(); tick();
    check("reset displayNumber", displayNumber, 16'h0000);
    check("reset lives", lives, 3);
    check("reset game_over", game_over, 0);
    check("reset busy", busy, 0);
    reset = 1'b1;
    tick();

    // Start latency and first win with three timer ticks elapsed
    e = cyc + 1;
    start = 1'b1; tick();
    runTo(e + 2); won[1] = 1'b1; tick();
    runTo(e + 10);
    check("win before PLAY ignored", displayNumber, 16'h0000);
    runTo(e + 33); won[0] = 1'b1; tick();
    busyCnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (busy) busyCnt++;
      if (i == 4) check("score before commit", displayNumber, 16'h0000);
    end
    check("busy cycles first win", busyCnt, 4);
    check("score first win", displayNumber, expFirst);
    won = 4'b0;

    // Back-to-back wins: second edge arrives mid-add
    repeat (3) tick();
    won[2] = 1'b1; tick(); won[2] = 1'b0; tick(); tick();
    won[3] = 1'b1; tick(); won[3] = 1'b0;
    repeat (12) tick();

    // Collisions and the invulnerability window
    col = 1'b1; tick(); col = 1'b0; tick();
    check("lives after hit 1", lives, 2);
    repeat (3) tick();
    col = 1'b1; tick(); col = 1'b0; tick(); tick();
    check("lives hit inside window", lives, 2);
    repeat (25) tick();
    col = 1'b1; tick(); col = 1'b0; tick();
    check("lives after hit 2", lives, 1);
    repeat (25) tick();

    // Win and final collision on the same edge
    won[0] = 1'b1; col = 1'b1; tick();
    won[0] = 1'b0; col = 1'b0;
    busyCnt = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (busy) busyCnt++;
      if (i == 4) check("game_over during add", game_over, 0);
    end
    check("busy cycles last add", busyCnt, 4);
    check("game_over after add", game_over, 1);
    check("lives at game over", lives, 0);
    won[1] = 1'b1; tick(); won[1] = 1'b0;
    repeat (8) tick();
    check("game_over held", game_over, 1);

    // Restart, then reset in the middle of an add
    start = 1'b0; repeat (3) tick();
    start = 1'b1; repeat (5) tick();
    won[2] = 1'b1; tick(); won[2] = 1'b0; repeat (6) tick();
    won[3] = 1'b1; tick(); won[3] = 1'b0; repeat (3) tick();
    #2 reset = 1'b0;
    mReset();
    #1;
    check("mid-add reset displayNumber", displayNumber, 16'h0000);
    check("mid-add reset busy", busy, 0);
    check("mid-add reset lives", lives, 3);
    check("mid-add reset game_over", game_over, 0);
    start = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    won[0] = 1'b1; tick(); won[0] = 1'b0;
    repeat (8) tick();
    check("IDLE ignores win", displayNumber, 16'h0000);
    check("IDLE not busy", busy, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 7) == 0) won[j] = ~won[j];
      if ($urandom_range(0, 15) == 0) col = ~col;
      if ($urandom_range(0, 40) == 0) start = ~start;
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b0;
        mReset();
        tick();
        #2 reset = 1'b1;
      end
      tick();
    end

    // Saturation at 9999
    #2 reset = 1'b0;
    mReset();
    start = 1'b0; won = 4'b0; col = 1'b0;
    tick();
    #2 reset = 1'b1;
    start = 1'b1; repeat (5) tick();
    for (int n = 0; n < 105; n++) begin
      won[0] = 1'b1; tick(); won[0] = 1'b0; repeat (6) tick();
    end
    check("score saturated", displayNumber, 16'h9999);
    won[1] = 1'b1; tick(); won[1] = 1'b0; repeat (7) tick();
    check("score no wrap", displayNumber, 16'h9999);

    chkOn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
